// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command responder:
//   - data width constants (operand / result)
//   - 5-bit opcode encoding
//   - responder FSM state enum
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int OPND_W = 32;
    localparam int RES_W  = 64;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00001;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00010;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SHL1 = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR1 = 5'b00101;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00110;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00111;
    localparam logic [OP_W-1:0] OP_INC  = 5'b01000;
    localparam logic [OP_W-1:0] OP_DEC  = 5'b01010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Iterative 32x32 -> 64 shift-add multiplier, one partial product per cycle.
//   clk, rst   clock / asynchronous active-low reset
//   start      load operands, clear accumulator and counter, go busy
//   a, b       unsigned operands (sampled on start)
//   busy       iterating
//   done       last iteration in progress; product is valid this cycle
//   product    accumulator plus the current partial product
// The top level registers product on the edge where done is high, so the
// final (cnt=31) term never needs an extra cycle to land in the accumulator.
// ---------------------------------------------------------------------------
module alu_mul_iter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [RES_W-1:0]  product
);

    logic [RES_W-1:0]  a_q;
    logic [OPND_W-1:0] b_q;
    logic [RES_W-1:0]  acc_q;
    logic [4:0]        cnt_q;
    logic              busy_q;
    logic [RES_W-1:0]  partial;
    logic [RES_W-1:0]  acc_sum;

    assign partial = b_q[cnt_q] ? (a_q << cnt_q) : '0;
    assign acc_sum = acc_q + partial;

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == 5'd31);
    assign product = acc_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            a_q    <= {{(RES_W-OPND_W){1'b0}}, a};
            b_q    <= b;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_responder.sv
// ---------------------------------------------------------------------------
// alu_cmd_responder
// Valid/ready front-end serving one ALU command at a time.
//   clk, rst            clock / asynchronous active-low reset
//   en                  acceptance enable (gates req_ready only)
//   req_valid/ready     command handshake
//   req_op, req_a/b     5-bit opcode, 32-bit unsigned operands
//   req_tag             echoed on rsp_tag
//   rsp_valid/ready     response handshake
//   rsp_data            64-bit result (0 on error)
//   rsp_tag, rsp_err    command tag, illegal/disabled opcode flag
// Optional feature macro: ALU_RSP_MUL_EN enables the 32-cycle iterative
// multiply for opcode 00011; without it that opcode is reported illegal.
// ---------------------------------------------------------------------------
module alu_cmd_responder
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [OPND_W-1:0] req_a,
    input  logic [OPND_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err
);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             load_alu;
    logic [RES_W-1:0] a64;
    logic [RES_W-1:0] b64;
    logic [RES_W-1:0] alu_res;
    logic             alu_err;

    // rst is folded in so req_ready reads 0 while reset is held, and follows
    // en from the very first cycle after release.
    assign req_ready = rst && en &&
                       ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);

    assign a64 = {{(RES_W-OPND_W){1'b0}}, req_a};
    assign b64 = {{(RES_W-OPND_W){1'b0}}, req_b};

    // Single-cycle result mux, evaluated straight off the request bus.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (req_op)
            OP_ADD:  alu_res = a64 + b64;
            OP_SUB:  alu_res = a64 - b64;
            OP_SHL1: alu_res = a64 << 1;
            OP_SHR1: alu_res = a64 >> 1;
            OP_AND:  alu_res = a64 & b64;
            OP_OR:   alu_res = a64 | b64;
            OP_INC:  alu_res = a64 + 64'd1;
            OP_DEC:  alu_res = a64 - 64'd1;
`ifdef ALU_RSP_MUL_EN
            OP_MUL:  alu_res = '0;   // served by the iterative multiplier
`endif
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_RSP_MUL_EN
    logic             mul_start;
    logic             load_mul;
    logic             mul_busy;
    logic             mul_done;
    logic [RES_W-1:0] mul_product;
    logic [TAG_W-1:0] mul_tag_q;

    alu_mul_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (req_a),
        .b       (req_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Tag of the in-flight multiply, held until the result is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_tag_q <= '0;
        end else if (mul_start) begin
            mul_tag_q <= req_tag;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        load_alu = 1'b0;
`ifdef ALU_RSP_MUL_EN
        mul_start = 1'b0;
        load_mul  = 1'b0;
`endif
        case (state_q)
            IDLE, RESP: begin
                if ((state_q == RESP) && rsp_ready) begin
                    state_d = IDLE;
                end
                // A command taken on the response handshake edge overrides
                // the return to IDLE (back-to-back throughput).
                if (accept) begin
                    state_d  = RESP;
                    load_alu = 1'b1;
`ifdef ALU_RSP_MUL_EN
                    if (req_op == OP_MUL) begin
                        state_d   = MUL;
                        load_alu  = 1'b0;
                        mul_start = 1'b1;
                    end
`endif
                end
            end
`ifdef ALU_RSP_MUL_EN
            MUL: begin
                if (mul_done) begin
                    state_d  = RESP;
                    load_mul = 1'b1;
                end else if (!mul_busy) begin
                    // Multiplier lost its job without finishing: drop it
                    // rather than hang waiting for a done that never comes.
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; rsp_* only move on entry to RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rsp_data <= '0;
            rsp_tag  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_alu) begin
                rsp_data <= alu_err ? '0 : alu_res;
                rsp_tag  <= req_tag;
                rsp_err  <= alu_err;
            end
`ifdef ALU_RSP_MUL_EN
            else if (load_mul) begin
                rsp_data <= mul_product;
                rsp_tag  <= mul_tag_q;
                rsp_err  <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_responder
// Directed-vector bench for alu_cmd_responder. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_cmd_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_cmd_responder #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
    endtask

    // Single-cycle command from IDLE with rsp_ready=1; called on a negedge.
    task automatic do_cmd(input string name, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [63:0] exp_d,
                          input logic exp_e);
        drive_req(op, a, b, tag);
        chk({name, " req_ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk({name, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({name, " rsp_data"}, rsp_data, exp_d);
        chk({name, " rsp_tag"}, 64'(rsp_tag), 64'(tag));
        chk({name, " rsp_err"}, 64'(rsp_err), 64'(exp_e));
        @(negedge clk);
        chk({name, " rsp_valid drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int bad;
        rst       = 1'b0;
        en        = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;

        // Reset values while rst is held low
        repeat (2) @(negedge clk);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst rsp_data", rsp_data, 64'd0);
        chk("rst rsp_tag", 64'(rsp_tag), 64'd0);
        chk("rst rsp_err", 64'(rsp_err), 64'd0);
        rst = 1'b1;
        #1;
        chk("post-rst req_ready", 64'(req_ready), 64'd1);
        en = 1'b0;
        #1;
        chk("en=0 req_ready", 64'(req_ready), 64'd0);
        en = 1'b1;
        @(negedge clk);

        do_cmd("add", 5'b00001, 32'd5, 32'd3, 4'd2, 64'd8, 1'b0);
        do_cmd("sub", 5'b00010, 32'd3, 32'd5, 4'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        do_cmd("shl1", 5'b00100, 32'h8000_0000, 32'd0, 4'd1, 64'h1_0000_0000, 1'b0);
        do_cmd("dec", 5'b01010, 32'd0, 32'd0, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        do_cmd("inc", 5'b01000, 32'hFFFF_FFFF, 32'd0, 4'd4, 64'h1_0000_0000, 1'b0);
        do_cmd("shr1", 5'b00101, 32'h0000_0003, 32'd0, 4'd8, 64'd1, 1'b0);
        do_cmd("and", 5'b00110, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd10, 64'h00F0_1234, 1'b0);
        do_cmd("illegal", 5'b01001, 32'd11, 32'd22, 4'd12, 64'd0, 1'b1);
        do_cmd("add after illegal", 5'b00001, 32'd100, 32'd23, 4'd13, 64'd123, 1'b0);

`ifdef ALU_RSP_MUL_EN
        // Multiply: result 32 cycles after accept, req_ready low throughout
        drive_req(5'b00011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd14);
        chk("mul req_ready", 64'(req_ready), 64'd1);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            if (rsp_valid || req_ready) bad++;
        end
        chk("mul busy cycles", 64'(bad), 64'd0);
        @(negedge clk);
        chk("mul rsp_valid", 64'(rsp_valid), 64'd1);
        chk("mul rsp_data", rsp_data, 64'hFFFF_FFFE_0000_0001);
        chk("mul rsp_tag", 64'(rsp_tag), 64'd14);
        chk("mul rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        chk("mul rsp_valid drop", 64'(rsp_valid), 64'd0);
`else
        do_cmd("mul disabled", 5'b00011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd14, 64'd0, 1'b1);
`endif

        // Backpressure with a queued request behind it
        rsp_ready = 1'b0;
        drive_req(5'b00111, 32'h0000_00F0, 32'h0000_000F, 4'd5);
        @(negedge clk);
        drive_req(5'b00001, 32'd1, 32'd2, 4'd6);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (!rsp_valid || rsp_data !== 64'hFF || rsp_tag !== 4'd5 || req_ready) bad++;
            @(negedge clk);
        end
        chk("bp hold", 64'(bad), 64'd0);
        chk("bp data", rsp_data, 64'hFF);
        rsp_ready = 1'b1;
        #1;
        chk("bp release req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b rsp_valid", 64'(rsp_valid), 64'd1);
        chk("b2b rsp_data", rsp_data, 64'd3);
        chk("b2b rsp_tag", 64'(rsp_tag), 64'd6);
        @(negedge clk);
        chk("b2b rsp_valid drop", 64'(rsp_valid), 64'd0);

        // Reset in the 10th cycle of an in-flight command
        rsp_ready = 1'b0;
`ifdef ALU_RSP_MUL_EN
        drive_req(5'b00011, 32'd1234, 32'd5678, 4'd11);
`else
        drive_req(5'b00001, 32'd1234, 32'd5678, 4'd11);
`endif
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid-rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid-rst req_ready", 64'(req_ready), 64'd0);
        chk("mid-rst rsp_data", rsp_data, 64'd0);
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        chk("no rsp after rst", 64'(bad), 64'd0);
        do_cmd("add after rst", 5'b00001, 32'd7, 32'd9, 4'd3, 64'd16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_responder.md
# alu_cmd_responder

Request/response front-end that serves ALU commands over a valid/ready handshake. It accepts one command (opcode, two 32-bit operands, tag) and returns one 64-bit result with the same tag. Single-cycle ops answer in one cycle; multiply runs as an iterative shift-add. It sits between any command initiator (CPU-side sequencer or hardware test driver) and the downstream consumer of results, and uses the team's existing 5-bit opcode encoding.

## Interface
- TAG_W, default 4: width of the request/response tag.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  acceptance enable; low forces req_ready low and does not stall in-flight work.
- req_valid  in  1  command present.
- req_ready  out  1  command accepted on the edge where req_valid and req_ready are both high.
- req_op  in  5  opcode.
- req_a, req_b  in  32 each  operands, unsigned.
- req_tag  in  TAG_W  echoed on the response.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes the result on the edge where rsp_valid and rsp_ready are both high.
- rsp_data  out  64  result.
- rsp_tag  out  TAG_W  tag of the command.
- rsp_err  out  1  illegal or disabled opcode.

## Operation
- Opcodes: 00001 add, 00010 sub, 00011 mul, 00100 shl1, 00101 shr1, 00110 and, 00111 or, 01000 inc, 01010 dec. Every other code is illegal.
- Arithmetic: zero-extend operands to 64 bits and compute modulo 2^64.
  - add gives a+b.
  - sub gives a-b, so 3-5 = 64'hFFFF_FFFF_FFFF_FFFE.
  - shl1 gives a<<1 and keeps bit 32.
  - shr1 gives a>>1.
  - and / or are bitwise over the zero-extended operands.
  - inc gives a+1.
  - dec gives a-1, so 0 gives all ones.
  - mul gives the full 64-bit product.
- Illegal opcode: rsp_err=1, rsp_data=0, normal single-cycle latency.
- FSM states:
  - IDLE: req_ready=en.
  - MUL: iterating; req_ready=0.
  - RESP: rsp_valid=1.
- Transitions:
  - IDLE, on accept of a non-mul opcode, goes to RESP. The result, tag and err are registered.
  - IDLE, on accept of mul, goes to MUL. This loads the operands, clears the accumulator and sets cnt=0.
  - MUL adds (a<<cnt) when b[cnt]=1, then increments cnt. When cnt=31 the next state is RESP.
  - RESP with rsp_ready=0 stays in RESP and holds all rsp_* stable.
  - RESP with rsp_ready=1 goes to IDLE, or accepts a new command in the same cycle (see below).
- Back-to-back: req_ready = en && (state==IDLE || (state==RESP && rsp_ready)). A command accepted on the same edge as the handshake goes directly to RESP (non-mul) or MUL (mul).
- At most one command in flight. Responses are returned in acceptance order.

## Timing
- Reset values (asynchronous, while rst=0): state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, cnt=0, accumulator=0.
- After rst deasserts, req_ready follows en from the first cycle.
- Non-mul latency: rsp_valid is high in the cycle after the accepting edge. Throughput is one command per cycle while rsp_ready=1.
- Mul latency: rsp_valid rises 32 cycles after the accepting edge. Throughput is one mul per 33 cycles when rsp_ready=1.
- en falling during MUL or RESP does not affect completion or delivery.
- Reset during MUL or RESP drops the command. No response is produced.
- rsp_data, rsp_tag and rsp_err change only on the edge that enters RESP.

## Configuration
- ALU_RSP_MUL_EN defined: opcode 00011 runs the iterative multiply as above.
- ALU_RSP_MUL_EN undefined:
  - opcode 00011 is illegal: rsp_err=1, rsp_data=0, one-cycle latency;
  - the MUL state, counter and accumulator are not compiled.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_DEC);
  - the state enum (IDLE, MUL, RESP);
  - the 32/64 data width constants.
- Sub-module alu_mul_iter holds the accumulator, counter and done flag. It has ports start, a, b, busy, done and product, and is instantiated only under ALU_RSP_MUL_EN.
- The single-cycle result mux is combinational in the top level.

## Test plan
- Reset with en=1, then one command: add a=5, b=3, tag=2 with rsp_ready=1.
  - Expect rsp_valid in the next cycle, rsp_data=8, rsp_tag=2, rsp_err=0.
- Run the sub, shl1 and dec cases:
  - sub a=3, b=5 gives 64'hFFFF_FFFF_FFFF_FFFE;
  - shl1 a=32'h8000_0000 gives 64'h1_0000_0000;
  - dec a=0 gives 64'hFFFF_FFFF_FFFF_FFFF.
- mul a=b=32'hFFFF_FFFF gives 64'hFFFF_FFFE_0000_0001 exactly 32 cycles after accept, with req_ready=0 throughout. Without ALU_RSP_MUL_EN the same command gives rsp_err=1 and data 0.
- Illegal opcode 01001 gives rsp_err=1, rsp_data=0 in the next cycle. The following add is accepted normally.
- Backpressure: hold rsp_ready=0 for 3 cycles on an or a=32'hF0, b=32'h0F. Expect rsp_data=64'hFF to stay stable and req_ready=0. Release it, and a queued request is accepted on the same edge.
- Drive rst=0 in the 10th cycle of a mul. Expect rsp_valid=0 immediately. No response appears after release, and the next add works.
